// File: rtl/wb_pkg.sv
// Shared opcodes, load funct3 codes and FSM state type
// for the multi-lane write-back stage.
package wb_pkg;

   localparam logic [6:0] OPC_LOAD = 7'b0000011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE,
      WAIT
   } wb_state_e;

endpackage

// File: rtl/write_back_multi_if.sv
// Lane bundle, data-memory port and status bus
// of the multi-lane write-back stage.
interface write_back_multi_if #(
   parameter int NUM_LANES = 2,
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int CNT_W     = 64
);
   localparam int RW = $clog2(NUM_LANES + 1);

   logic [NUM_LANES-1:0]            valid_i;
   logic [NUM_LANES-1:0]            we_i;
   logic [NUM_LANES-1:0][XLEN-1:0]  pc_i;
   logic [NUM_LANES-1:0][31:0]      instr_i;
   logic [NUM_LANES-1:0][XLEN-1:0]  alu_i;
   logic                            mem_req_o;
   logic [XLEN-1:0]                 mem_addr_o;
   logic                            mem_rsp_valid_i;
   logic [XLEN-1:0]                 mem_rdata_i;
   logic                            stall_o;
   logic                            misalign_o;
   logic [RW-1:0]                   retired_o;
   logic [CNT_W-1:0]                retire_cnt_o;
   logic [NREGS-1:0][XLEN-1:0]      reg_file_o;

   modport master (
      output valid_i, we_i, pc_i, instr_i, alu_i,
      output mem_rsp_valid_i, mem_rdata_i,
      input  mem_req_o, mem_addr_o, stall_o, misalign_o,
      input  retired_o, retire_cnt_o, reg_file_o
   );

   modport slave (
      input  valid_i, we_i, pc_i, instr_i, alu_i,
      input  mem_rsp_valid_i, mem_rdata_i,
      output mem_req_o, mem_addr_o, stall_o, misalign_o,
      output retired_o, retire_cnt_o, reg_file_o
   );

endinterface

// File: rtl/wb_load_align.sv
// Byte-lane alignment and extension of a returned
// load word; flags misaligned half/word accesses.
module wb_load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            misalign
);

   logic [XLEN-1:0] sh;

   always_comb begin
      sh       = rdata >> {off, 3'b000};
      data     = '0;
      misalign = 1'b0;
      case (funct3)
         F3_LB:  data = {{(XLEN-8){sh[7]}}, sh[7:0]};
         F3_LBU: data = {{(XLEN-8){1'b0}}, sh[7:0]};
         F3_LH: begin
            if (off[0]) misalign = 1'b1;
            else data = {{(XLEN-16){sh[15]}}, sh[15:0]};
         end
         F3_LHU: begin
            if (off[0]) misalign = 1'b1;
            else data = {{(XLEN-16){1'b0}}, sh[15:0]};
         end
         F3_LW: begin
            if (off != 2'b00) misalign = 1'b1;
            else data = sh;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/write_back_multi.sv
// N-lane write-back stage: load handshake on lane 0,
// register file with youngest-lane-wins writes, retire counter.
module write_back_multi
   import wb_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int CNT_W     = 64
) (
   input logic clk_i,
   input logic rstn_i,
   write_back_multi_if.slave bus
);

   localparam int RW = $clog2(NUM_LANES + 1);
   localparam int AW = $clog2(NREGS);

   wb_state_e state, state_n;

   logic [NREGS-1:0][XLEN-1:0]     rf;
   logic [CNT_W-1:0]               cnt;
   logic [NUM_LANES-1:0][XLEN-1:0] wdata;
   logic [NUM_LANES-1:0]           lane_we;
   logic [NUM_LANES-1:0][AW-1:0]   rd;
   logic [RW-1:0]                  pop;
   logic [XLEN-1:0]                ld_data;
   logic                           ld_mis;
   logic                           is_load;
   logic                           commit;
   logic                           mem_req;
   logic                           stall;
   logic                           misalign;
   logic                           unused_bits;

   assign is_load = bus.valid_i[0]
                 && (bus.instr_i[0][6:0] == OPC_LOAD);

   wb_load_align #(.XLEN(XLEN)) u_align (
      .rdata    (bus.mem_rdata_i),
      .off      (bus.alu_i[0][1:0]),
      .funct3   (bus.instr_i[0][14:12]),
      .data     (ld_data),
      .misalign (ld_mis)
   );

   // Lane 1+ load opcodes are illegal and simply never write.
   always_comb begin
      wdata       = '0;
      lane_we     = '0;
      rd          = '0;
      pop         = '0;
      unused_bits = 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
         rd[l]       = bus.instr_i[l][7 +: AW];
         pop         = pop + RW'(bus.valid_i[l]);
         unused_bits = unused_bits ^ (^bus.instr_i[l][31:15]);
         lane_we[l]  = bus.valid_i[l] && bus.we_i[l];
         unique case (1'b1)
            (bus.instr_i[l][6:0] == OPC_JAL),
            (bus.instr_i[l][6:0] == OPC_JALR):
               wdata[l] = bus.pc_i[l] + XLEN'(4);
            (bus.instr_i[l][6:0] == OPC_LOAD): begin
               if (l == 0) wdata[l] = ld_data;
               else lane_we[l] = 1'b0;
            end
            default: wdata[l] = bus.alu_i[l];
         endcase
      end
   end

   always_comb begin
      state_n  = state;
      mem_req  = 1'b0;
      stall    = 1'b0;
      commit   = 1'b0;
      misalign = 1'b0;
      unique case (state)
         IDLE: begin
            if (is_load) begin
               mem_req = 1'b1;
               stall   = 1'b1;
               state_n = WAIT;
            end else begin
               commit = 1'b1;
            end
         end
         WAIT: begin
            if (bus.mem_rsp_valid_i) begin
               commit   = 1'b1;
               misalign = ld_mis && is_load;
               state_n  = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Later lanes overwrite earlier ones, so the youngest write wins.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state <= IDLE;
         cnt   <= '0;
         rf    <= '0;
      end else begin
         state <= state_n;
         if (commit) begin
            cnt <= cnt + CNT_W'(pop);
            for (int l = 0; l < NUM_LANES; l++)
               if (lane_we[l] && rd[l] != '0)
                  rf[rd[l]] <= wdata[l];
         end
      end
   end

   assign bus.mem_req_o    = mem_req;
   assign bus.mem_addr_o   = {bus.alu_i[0][XLEN-1:2], 2'b00};
   assign bus.stall_o      = stall;
   assign bus.misalign_o   = misalign;
   assign bus.retired_o    = commit ? pop : '0;
   assign bus.retire_cnt_o = cnt;
   assign bus.reg_file_o   = rf;

endmodule

// File: tb/tb_write_back_multi.sv
// Bench for write_back_multi: vector table, directed load
// sequences and random bundles against a reference model.
module tb_write_back_multi;

   localparam logic [6:0] LOAD = 7'b0000011;
   localparam logic [6:0] ADDI = 7'b0010011;
   localparam logic [6:0] OPR  = 7'b0110011;
   localparam logic [6:0] LUI  = 7'b0110111;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   write_back_multi_if #(.NUM_LANES(2), .XLEN(32),
      .NREGS(32), .CNT_W(64)) bus ();

   write_back_multi #(.NUM_LANES(2), .XLEN(32),
      .NREGS(32), .CNT_W(64)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0]     mrf [32];
   longint unsigned mcnt;

   typedef struct {
      logic [1:0]  v;
      logic [1:0]  we;
      logic [31:0] i0, i1, a0, a1, p0, p1;
      logic [1:0]  ret;
      logic [4:0]  rd;
      logic [31:0] val;
   } vec_t;

   vec_t tbl [6];

   always @(negedge clk)
      if (rstn && bus.valid_i[1] && bus.instr_i[1][6:0] == LOAD)
         $error("illegal load opcode on lane 1");

   function automatic logic [31:0] mk(logic [6:0] o,
      logic [4:0] r, logic [2:0] f3);
      return {17'd0, f3, r, o};
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_rf(input string tag);
      for (int i = 0; i < 32; i++)
         chk($sformatf("%s x%0d", tag, i), 64'(bus.reg_file_o[i]),
            64'(mrf[i]));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      mcnt = 0;
   endtask

   function automatic int popc(logic [1:0] v);
      return int'(v[0]) + int'(v[1]);
   endfunction

   function automatic logic [31:0] sx(logic [31:0] x, int bits);
      logic [31:0] m;
      m = (32'd1 << bits) - 1;
      x = x & m;
      if (x >= (32'd1 << (bits - 1))) return x | ~m;
      return x;
   endfunction

   task automatic ref_load(input logic [31:0] w, input logic [31:0] a,
      input logic [2:0] f3, output logic [31:0] d, output logic mis);
      int off;
      logic [31:0] s;
      off = int'(a % 4);
      s = w >> (8 * off);
      d = 0;
      mis = 0;
      case (f3)
         3'd0: d = sx(s, 8);
         3'd4: d = s & 32'hFF;
         3'd1: if (off % 2 == 1) mis = 1; else d = sx(s, 16);
         3'd5: if (off % 2 == 1) mis = 1; else d = s & 32'hFFFF;
         3'd2: if (off != 0) mis = 1; else d = s;
         default: ;
      endcase
   endtask

   task automatic model_commit(input logic [31:0] ld);
      for (int l = 0; l < 2; l++) begin
         logic [6:0] o;
         logic [4:0] r;
         logic [31:0] val;
         o = bus.instr_i[l][6:0];
         r = bus.instr_i[l][11:7];
         if (o == JAL || o == JALR) val = bus.pc_i[l] + 4;
         else if (o == LOAD) val = ld;
         else val = bus.alu_i[l];
         if (bus.valid_i[l] && bus.we_i[l] && r != 0
             && !(l > 0 && o == LOAD))
            mrf[r] = val;
      end
      mcnt += longint'(popc(bus.valid_i));
   endtask

   task automatic set_in(input logic [1:0] v, input logic [1:0] we,
      input logic [31:0] i0, input logic [31:0] i1,
      input logic [31:0] a0, input logic [31:0] a1,
      input logic [31:0] p0, input logic [31:0] p1);
      bus.valid_i    = v;
      bus.we_i       = we;
      bus.instr_i[0] = i0;
      bus.instr_i[1] = i1;
      bus.alu_i[0]   = a0;
      bus.alu_i[1]   = a1;
      bus.pc_i[0]    = p0;
      bus.pc_i[1]    = p1;
   endtask

   task automatic alu_cycle(input string tag);
      #1;
      chk({tag, " req"}, 64'(bus.mem_req_o), 64'd0);
      chk({tag, " stall"}, 64'(bus.stall_o), 64'd0);
      chk({tag, " mis"}, 64'(bus.misalign_o), 64'd0);
      chk({tag, " ret"}, 64'(bus.retired_o), 64'(popc(bus.valid_i)));
      @(posedge clk);
      model_commit('0);
      #1;
      chk({tag, " cnt"}, bus.retire_cnt_o, mcnt);
   endtask

   task automatic load_txn(input string tag, input int lat,
      input logic [31:0] rdata, input bit full);
      logic [31:0] d;
      logic mis;
      #1;
      chk({tag, " req"}, 64'(bus.mem_req_o), 64'd1);
      chk({tag, " stall0"}, 64'(bus.stall_o), 64'd1);
      chk({tag, " addr"}, 64'(bus.mem_addr_o),
         64'(bus.alu_i[0] & ~32'd3));
      chk({tag, " ret0"}, 64'(bus.retired_o), 64'd0);
      @(posedge clk);
      for (int k = 0; k < lat - 2; k++) begin
         @(negedge clk);
         #1;
         chk({tag, " req_w"}, 64'(bus.mem_req_o), 64'd0);
         chk({tag, " stall_w"}, 64'(bus.stall_o), 64'd1);
         chk({tag, " ret_w"}, 64'(bus.retired_o), 64'd0);
         if (full) chk_rf({tag, " hold"});
         @(posedge clk);
      end
      @(negedge clk);
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = rdata;
      ref_load(rdata, bus.alu_i[0], bus.instr_i[0][14:12], d, mis);
      #1;
      chk({tag, " stall_r"}, 64'(bus.stall_o), 64'd0);
      chk({tag, " req_r"}, 64'(bus.mem_req_o), 64'd0);
      chk({tag, " mis"}, 64'(bus.misalign_o), 64'(mis));
      chk({tag, " ret_r"}, 64'(bus.retired_o), 64'(popc(bus.valid_i)));
      @(posedge clk);
      model_commit(d);
      #1;
      bus.mem_rsp_valid_i = 1'b0;
      chk({tag, " cnt"}, bus.retire_cnt_o, mcnt);
      if (full) chk_rf({tag, " rf"});
   endtask

   initial begin
      tbl[0] = '{2'b11, 2'b11, mk(ADDI, 5, 0), mk(ADDI, 5, 0),
                 32'h11, 32'h22, 32'h0, 32'h4, 2'd2, 5'd5, 32'h22};
      tbl[1] = '{2'b11, 2'b11, mk(ADDI, 0, 0), mk(ADDI, 0, 0),
                 32'h55, 32'h66, 32'h8, 32'hC, 2'd2, 5'd0, 32'h0};
      tbl[2] = '{2'b11, 2'b11, mk(ADDI, 2, 0), mk(JAL, 1, 0),
                 32'h7, 32'h99, 32'h2FC, 32'h300, 2'd2, 5'd1, 32'h304};
      tbl[3] = '{2'b01, 2'b11, mk(ADDI, 3, 0), mk(ADDI, 3, 0),
                 32'hAB, 32'hCD, 32'h10, 32'h14, 2'd1, 5'd3, 32'hAB};
      tbl[4] = '{2'b11, 2'b01, mk(ADDI, 4, 0), mk(ADDI, 4, 0),
                 32'h10, 32'h20, 32'h18, 32'h1C, 2'd2, 5'd4, 32'h10};
      tbl[5] = '{2'b01, 2'b01, mk(JALR, 6, 0), mk(ADDI, 7, 0),
                 32'hDEAD, 32'h1, 32'h1000, 32'h1004, 2'd1, 5'd6, 32'h1004};

      set_in(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rdata_i     = '0;
      model_reset();
      #12;
      chk("rst req", 64'(bus.mem_req_o), 64'd0);
      chk("rst stall", 64'(bus.stall_o), 64'd0);
      chk("rst mis", 64'(bus.misalign_o), 64'd0);
      chk("rst ret", 64'(bus.retired_o), 64'd0);
      chk("rst cnt", bus.retire_cnt_o, 64'd0);
      chk_rf("rst");
      @(negedge clk);
      rstn = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         set_in(tbl[i].v, tbl[i].we, tbl[i].i0, tbl[i].i1,
            tbl[i].a0, tbl[i].a1, tbl[i].p0, tbl[i].p1);
         #1;
         chk($sformatf("tbl%0d ret", i), 64'(bus.retired_o),
            64'(tbl[i].ret));
         alu_cycle($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d val", i),
            64'(bus.reg_file_o[tbl[i].rd]), 64'(tbl[i].val));
      end
      chk("tbl cnt", bus.retire_cnt_o, 64'd10);

      @(negedge clk);
      set_in(2'b01, 2'b01, mk(LOAD, 7, 3'd0), mk(ADDI, 0, 0),
         32'h1003, 0, 32'h40, 32'h44);
      #1;
      chk("lb addr", 64'(bus.mem_addr_o), 64'h1000);
      load_txn("lb", 3, 32'h80FFFFFF, 1);
      chk("lb x7", 64'(bus.reg_file_o[7]), 64'hFFFFFF80);

      @(negedge clk);
      set_in(2'b01, 2'b01, mk(LOAD, 8, 3'd5), mk(ADDI, 0, 0),
         32'h1002, 0, 32'h48, 32'h4C);
      load_txn("lhu", 2, 32'hBEEF1234, 1);
      chk("lhu x8", 64'(bus.reg_file_o[8]), 64'h0000BEEF);

      @(negedge clk);
      set_in(2'b01, 2'b01, mk(LOAD, 9, 3'd2), mk(ADDI, 0, 0),
         32'h1001, 0, 32'h50, 32'h54);
      load_txn("lw_mis", 2, 32'hCAFEF00D, 1);
      chk("lw_mis x9", 64'(bus.reg_file_o[9]), 64'h0);
      @(negedge clk);
      set_in(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      #1;
      chk("mis pulse end", 64'(bus.misalign_o), 64'd0);

      @(negedge clk);
      set_in(2'b11, 2'b11, mk(LOAD, 10, 3'd2), mk(JAL, 1, 0),
         32'h2000, 32'h0, 32'h1FC, 32'h200);
      load_txn("ld_jal", 4, 32'h12345678, 1);
      chk("ld_jal x1", 64'(bus.reg_file_o[1]), 64'h204);
      chk("ld_jal x10", 64'(bus.reg_file_o[10]), 64'h12345678);

      @(negedge clk);
      set_in(2'b01, 2'b01, mk(LOAD, 11, 3'd2), mk(ADDI, 0, 0),
         32'h3000, 0, 32'h60, 32'h64);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      set_in(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      model_reset();
      #1;
      chk("rwait stall", 64'(bus.stall_o), 64'd0);
      chk("rwait req", 64'(bus.mem_req_o), 64'd0);
      chk("rwait cnt", bus.retire_cnt_o, 64'd0);
      chk_rf("rwait");
      @(negedge clk);
      rstn = 1'b1;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = 32'hFFFFFFFF;
      #1;
      chk("rlate stall", 64'(bus.stall_o), 64'd0);
      chk("rlate mis", 64'(bus.misalign_o), 64'd0);
      @(posedge clk);
      #1;
      bus.mem_rsp_valid_i = 1'b0;
      chk("rlate cnt", bus.retire_cnt_o, 64'd0);
      chk_rf("rlate");

      for (int it = 0; it < 150; it++) begin
         logic [6:0] ops [5];
         logic [2:0] f3s [8];
         logic [4:0] r0, r1;
         logic [31:0] i1;
         ops = '{ADDI, OPR, LUI, JAL, JALR};
         f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd0};
         r0 = 5'($urandom_range(0, 31));
         r1 = ($urandom % 4 == 0) ? r0 : 5'($urandom_range(0, 31));
         i1 = mk(ops[$urandom_range(0, 4)], r1, 3'd0);
         @(negedge clk);
         if ($urandom % 3 == 0) begin
            set_in(2'($urandom) | 2'b01, 2'($urandom),
               mk(LOAD, r0, f3s[$urandom_range(0, 7)]), i1,
               $urandom, $urandom, $urandom, $urandom);
            load_txn($sformatf("rnd%0d ld", it),
               int'($urandom_range(2, 5)), $urandom, 0);
         end else begin
            set_in(2'($urandom), 2'($urandom),
               mk(ops[$urandom_range(0, 4)], r0, 3'd0), i1,
               $urandom, $urandom, $urandom, $urandom);
            alu_cycle($sformatf("rnd%0d alu", it));
         end
         chk_rf($sformatf("rnd%0d", it));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
         n_chk, n_fail);
      $finish;
   end

endmodule
